aes_shift_rows_pipe: RTL and testbench

//  Registered, flow-controlled Rijndael ShiftRows/InvShiftRows stage. Generalised
//  to block sizes of 128, 192 and 256 bits. Direction is selectable per transaction.

---
 rtl/aes_shift_rows_pipe_pkg.sv | 20 ++
 rtl/aes_shift_rows_pipe_if.sv | 31 +++
 rtl/aes_shift_rows_pipe_skid.sv | 72 +++++++
 rtl/aes_shift_rows_pipe.sv | 61 ++++++
 tb/tb_aes_shift_rows_pipe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_shift_rows_pipe_pkg.sv
// Shared constants and index helpers for the Rijndael ShiftRows stage.
// Supports block sizes of 128, 192 and 256 bits.
package aes_pkg;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  // Row offsets: rows 2 and 3 shift one extra column for 256-bit blocks.
  function automatic int SHIFT_OFS(input int nb, input int r);
    if (nb == NB_256 && r >= 2) return r + 1;
    return r;
  endfunction

  // MSB bit position of byte k; byte 0 sits at the top of the state word.
  function automatic int BYTE_POS(input int k, input int sw);
    return sw - 1 - 8 * k;
  endfunction

endpackage

// File: rtl/aes_shift_rows_pipe_if.sv
// Upstream and downstream valid/ready channels of the ShiftRows stage.
// A beat moves on any rising clk edge where valid and ready are both high; once
// valid is raised, data/inv/tag hold until ready is seen high.
interface aes_shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  localparam int SW = 32 * NB;

  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    in_data;
  logic             in_inv;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_data;
  logic             out_inv;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_inv, out_tag
  );

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_inv, out_tag
  );

endinterface

// File: rtl/aes_shift_rows_pipe_skid.sv
// Two-entry valid/ready register slice: a main register drives the outputs and
// a skid register absorbs the one beat accepted while main is stalled.
module aes_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_valid;
  logic [W-1:0] r_main_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         r_in_ready;

  logic         w_accept;
  logic         w_drain;
  logic         w_main_valid_n;
  logic [W-1:0] w_main_data_n;
  logic         w_skid_valid_n;
  logic [W-1:0] w_skid_data_n;

  always_comb begin
    w_accept       = i_valid & r_in_ready;
    w_drain        = r_main_valid & i_ready;
    w_main_valid_n = r_main_valid;
    w_main_data_n  = r_main_data;
    w_skid_valid_n = r_skid_valid;
    w_skid_data_n  = r_skid_data;
    if (r_main_valid && !w_drain) begin
      if (w_accept) begin
        w_skid_valid_n = 1'b1;
        w_skid_data_n  = i_data;
      end
    end else if (r_skid_valid) begin
      // in_ready is low whenever skid is occupied, so no accept can collide here.
      w_main_valid_n = 1'b1;
      w_main_data_n  = r_skid_data;
      w_skid_valid_n = 1'b0;
    end else begin
      w_main_valid_n = w_accept;
      if (w_accept) w_main_data_n = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_n;
      r_main_data  <= w_main_data_n;
      r_skid_valid <= w_skid_valid_n;
      r_skid_data  <= w_skid_data_n;
      r_in_ready   <= !w_skid_valid_n;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage; direction chosen per beat by in_inv.
// The byte permutation is combinational ahead of the skid buffer.
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  aes_shift_rows_pipe_if.slave io_bus
);

  localparam int SW = 32 * NB;
  localparam int W  = SW + 1 + TAG_W;

  if (!(NB == NB_128 || NB == NB_192 || NB == NB_256)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [SW-1:0] w_fwd;
  logic [SW-1:0] w_inv;
  logic [SW-1:0] w_perm;
  logic [W-1:0]  w_in_word;
  logic [W-1:0]  w_out_word;

  for (genvar c = 0; c < NB; c++) begin : g_fwd_col
    for (genvar r = 0; r < 4; r++) begin : g_fwd_row
      localparam int DST = BYTE_POS(4 * c + r, SW);
      localparam int SRC = BYTE_POS(4 * ((c + SHIFT_OFS(NB, r)) % NB) + r, SW);
      assign w_fwd[DST -: 8] = io_bus.in_data[SRC -: 8];
    end
  end

  for (genvar c = 0; c < NB; c++) begin : g_inv_col
    for (genvar r = 0; r < 4; r++) begin : g_inv_row
      localparam int DST = BYTE_POS(4 * c + r, SW);
      localparam int SRC = BYTE_POS(4 * ((c - SHIFT_OFS(NB, r) + NB) % NB) + r, SW);
      assign w_inv[DST -: 8] = io_bus.in_data[SRC -: 8];
    end
  end

  assign w_perm    = io_bus.in_inv ? w_inv : w_fwd;
  assign w_in_word = {w_perm, io_bus.in_inv, io_bus.in_tag};

  aes_skid_buf #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (io_bus.in_valid),
    .o_ready (io_bus.in_ready),
    .i_data  (w_in_word),
    .o_valid (io_bus.out_valid),
    .i_ready (io_bus.out_ready),
    .o_data  (w_out_word)
  );

  assign io_bus.out_data = w_out_word[W-1 -: SW];
  assign io_bus.out_inv  = w_out_word[TAG_W];
  assign io_bus.out_tag  = w_out_word[TAG_W-1:0];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed and random checks of aes_shift_rows_pipe for NB = 4, 6 and 8.
// One instance per block size; sel picks which one the stimulus drives.
module tb_aes_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   sel      = 2'd0;
  logic         d_valid  = 1'b0;
  logic [255:0] d_data   = '0;
  logic         d_inv    = 1'b0;
  logic [3:0]   d_tag    = '0;
  logic         d_oready = 1'b1;

  aes_shift_rows_pipe_if #(.NB(4), .TAG_W(4)) bus4 ();
  aes_shift_rows_pipe_if #(.NB(6), .TAG_W(4)) bus6 ();
  aes_shift_rows_pipe_if #(.NB(8), .TAG_W(4)) bus8 ();

  aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (.clk(clk), .rst(rst), .io_bus(bus4));
  aes_shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (.clk(clk), .rst(rst), .io_bus(bus6));
  aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (.clk(clk), .rst(rst), .io_bus(bus8));

  assign bus4.in_valid  = d_valid && (sel == 2'd0);
  assign bus4.in_data   = d_data[127:0];
  assign bus4.in_inv    = d_inv;
  assign bus4.in_tag    = d_tag;
  assign bus4.out_ready = d_oready;
  assign bus6.in_valid  = d_valid && (sel == 2'd1);
  assign bus6.in_data   = d_data[191:0];
  assign bus6.in_inv    = d_inv;
  assign bus6.in_tag    = d_tag;
  assign bus6.out_ready = d_oready;
  assign bus8.in_valid  = d_valid && (sel == 2'd2);
  assign bus8.in_data   = d_data;
  assign bus8.in_inv    = d_inv;
  assign bus8.in_tag    = d_tag;
  assign bus8.out_ready = d_oready;

  logic         obs_in_ready, obs_valid, obs_inv;
  logic [255:0] obs_data;
  logic [3:0]   obs_tag;

  always_comb begin
    case (sel)
      2'd0: begin
        obs_in_ready = bus4.in_ready; obs_valid = bus4.out_valid;
        obs_data = {128'b0, bus4.out_data}; obs_inv = bus4.out_inv; obs_tag = bus4.out_tag;
      end
      2'd1: begin
        obs_in_ready = bus6.in_ready; obs_valid = bus6.out_valid;
        obs_data = {64'b0, bus6.out_data}; obs_inv = bus6.out_inv; obs_tag = bus6.out_tag;
      end
      default: begin
        obs_in_ready = bus8.in_ready; obs_valid = bus8.out_valid;
        obs_data = bus8.out_data; obs_inv = bus8.out_inv; obs_tag = bus8.out_tag;
      end
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ShiftRows on a right-justified state of 32*nb bits.
  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input logic inv);
    logic [255:0] o;
    int ofs, sc, sw;
    o  = '0;
    sw = 32 * nb;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        ofs = (nb == 8 && r >= 2) ? r + 1 : r;
        sc  = inv ? (c - ofs + nb) % nb : (c + ofs) % nb;
        o[sw-1-8*(4*c+r) -: 8] = d[sw-1-8*(4*sc+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic int nb_of(input logic [1:0] s);
    return (s == 2'd0) ? 4 : (s == 2'd1) ? 6 : 8;
  endfunction

  // Drive point: 3 time units after the rising edge; outputs are settled by then.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  logic [260:0] exp_q[$];
  logic         mon_on     = 1'b0;
  logic         acc_last   = 1'b0;
  logic         prev_stall = 1'b0;
  logic [260:0] prev_word  = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (prev_stall)
        check("hold", {3'b0, obs_valid, obs_data, obs_inv, obs_tag}, {3'b0, 1'b1, prev_word});
      if (obs_valid && d_oready) begin
        if (exp_q.size() == 0) check("spurious_beat", 264'd1, 264'd0);
        else check("rand_beat", {3'b0, obs_data, obs_inv, obs_tag}, {3'b0, exp_q.pop_front()});
      end
      if (d_valid && obs_in_ready)
        exp_q.push_back({ref_shift(nb_of(sel), d_data, d_inv), d_inv, d_tag});
      prev_stall = obs_valid && !d_oready;
      prev_word  = {obs_data, obs_inv, obs_tag};
    end else begin
      prev_stall = 1'b0;
    end
    acc_last = d_valid && obs_in_ready;
  end

  logic [255:0] asc;
  logic [255:0] fwd8;
  logic [255:0] mask;
  int           sent;
  int           budget;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", {263'b0, obs_valid}, 264'd0);
    check("rst_out_data",  {8'b0, obs_data}, 264'd0);
    check("rst_out_inv_tag", {259'b0, obs_inv, obs_tag}, 264'd0);
    check("rst_in_ready",  {263'b0, obs_in_ready}, 264'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {263'b0, obs_in_ready}, 264'd1);

    // FIPS-197 round 1 forward, NB=4
    sel = 2'd0; d_oready = 1'b1;
    d_valid = 1'b1; d_data = {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230}; d_inv = 1'b0; d_tag = 4'h5;
    tick();
    d_valid = 1'b0;
    check("fwd4_valid", {263'b0, obs_valid}, 264'd1);
    check("fwd4_data", {8'b0, obs_data}, {136'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
    check("fwd4_inv_tag", {259'b0, obs_inv, obs_tag}, {259'b0, 1'b0, 4'h5});
    tick();
    check("fwd4_drained", {263'b0, obs_valid}, 264'd0);

    // Inverse of the same state, NB=4
    d_valid = 1'b1; d_data = {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5}; d_inv = 1'b1; d_tag = 4'ha;
    tick();
    d_valid = 1'b0;
    check("inv4_data", {8'b0, obs_data}, {136'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
    check("inv4_inv_tag", {259'b0, obs_inv, obs_tag}, {259'b0, 1'b1, 4'ha});
    tick();

    // NB=8 ascending bytes, then inverse back
    sel = 2'd2;
    for (int k = 0; k < 32; k++) asc[255-8*k -: 8] = 8'(k);
    d_valid = 1'b1; d_data = asc; d_inv = 1'b0; d_tag = 4'h3;
    tick();
    d_valid = 1'b0;
    fwd8 = obs_data;
    check("fwd8_col0", {232'b0, fwd8[255:224]}, {232'b0, 32'h00050e13});
    check("fwd8_full", {8'b0, fwd8}, {8'b0, ref_shift(8, asc, 1'b0)});
    tick();
    d_valid = 1'b1; d_data = fwd8; d_inv = 1'b1; d_tag = 4'h4;
    tick();
    d_valid = 1'b0;
    check("inv8_roundtrip", {8'b0, obs_data}, {8'b0, asc});
    tick();

    // Backpressure fills main then skid; third beat stalls
    sel = 2'd0; d_oready = 1'b0; d_inv = 1'b0;
    d_valid = 1'b1; d_tag = 4'h1; d_data = {128'b0, {16{8'h11}}};
    tick();
    check("bp_ready_after_1", {263'b0, obs_in_ready}, 264'd1);
    d_tag = 4'h2; d_data = {128'b0, {16{8'h22}}};
    tick();
    check("bp_ready_after_2", {263'b0, obs_in_ready}, 264'd0);
    check("bp_head_1", {259'b0, obs_valid, obs_tag}, {259'b0, 1'b1, 4'h1});
    d_tag = 4'h3; d_data = {128'b0, 128'h0123456789abcdeffedcba9876543210};
    tick();
    check("bp_stall_3", {262'b0, obs_in_ready, obs_valid}, {262'b0, 1'b0, 1'b1});
    check("bp_head_still_1", {260'b0, obs_tag}, {260'b0, 4'h1});
    d_oready = 1'b1;
    tick();
    check("bp_out_2", {259'b0, obs_valid, obs_tag}, {259'b0, 1'b1, 4'h2});
    check("bp_ready_rise", {263'b0, obs_in_ready}, 264'd1);
    tick();
    d_valid = 1'b0;
    check("bp_out_3", {259'b0, obs_valid, obs_tag}, {259'b0, 1'b1, 4'h3});
    check("bp_out_3_data", {8'b0, obs_data},
          {8'b0, ref_shift(4, {128'b0, 128'h0123456789abcdeffedcba9876543210}, 1'b0)});
    tick();
    check("bp_empty", {263'b0, obs_valid}, 264'd0);

    // Reset with both entries full
    d_oready = 1'b0;
    d_valid = 1'b1; d_tag = 4'h7; d_data = {128'b0, {16{8'h77}}};
    tick();
    d_tag = 4'h8; d_data = {128'b0, {16{8'h88}}};
    tick();
    d_valid = 1'b0;
    check("full_before_rst", {262'b0, obs_in_ready, obs_valid}, {262'b0, 1'b0, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0; d_oready = 1'b1;
    check("rst_mid_valid", {263'b0, obs_valid}, 264'd0);
    check("rst_mid_ready", {263'b0, obs_in_ready}, 264'd0);
    tick();
    check("rst_mid_ready_rise", {263'b0, obs_in_ready}, 264'd1);
    check("rst_no_stale_1", {263'b0, obs_valid}, 264'd0);
    tick();
    check("rst_no_stale_2", {263'b0, obs_valid}, 264'd0);

    // Random traffic per block size against the reference model
    for (int s = 0; s < 3; s++) begin
      sel  = 2'(s);
      mask = (256'b1 << (32 * nb_of(sel))) - 256'b1;
      exp_q.delete();
      mon_on = 1'b1;
      sent = 0; budget = 0;
      d_valid = 1'b0;
      while (sent < 3400 && budget < 40000) begin
        tick();
        budget++;
        if (d_valid && acc_last) begin
          sent++;
          d_valid = 1'b0;
        end
        if (!d_valid && sent < 3400 && $urandom_range(0, 9) < 7) begin
          for (int w = 0; w < 8; w++) d_data[32*w +: 32] = $urandom();
          d_data  = d_data & mask;
          d_inv   = 1'($urandom_range(0, 1));
          d_tag   = 4'($urandom_range(0, 15));
          d_valid = 1'b1;
        end
        d_oready = ($urandom_range(0, 9) < 7);
      end
      check("rand_budget", {263'b0, budget < 40000}, 264'd1);
      d_valid = 1'b0; d_oready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      tick();
      mon_on = 1'b0;
      check("rand_drained", 264'(exp_q.size()), 264'd0);
      check("rand_idle", {263'b0, obs_valid}, 264'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
